pifo_root_calendar: RTL

Root-level PIFO calendar that stores scheduled packet descriptors sorted by rank. It sits directly downstream of the output-queue bypass checker and consumes its registered valid/bypass decision together with the matching registered descriptor. It also feeds its current head back to that checker as the calendar top. The head, or a bypassed descriptor, is emitted to the output port when that port requests a dequeue.

---
 rtl/pifo_root_pkg.sv | 38 +++
 rtl/pifo_calendar_cell.sv | 57 +++++
 rtl/pifo_root_calendar.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pifo_root_pkg.sv
// Shared constants, descriptor type and field helpers for the root PIFO calendar.
package pifo_root_pkg;

  localparam int unsigned CALENDAR_DEPTH           = 16;
  localparam int unsigned PIFO_ROOT_WIDTH          = 32;
  localparam int unsigned PIFO_RANK_WIDTH          = 19;
  localparam int unsigned BUFFER_ADDR_WIDTH        = 12;
  localparam int unsigned ROOT_RANK_START_POS      = 12;
  localparam int unsigned ROOT_RANK_END_POS        = 30;
  localparam int unsigned ROOT_PIFO_INFO_VALID_POS = 31;
  // Must be able to represent CALENDAR_DEPTH itself (the full count).
  localparam int unsigned COUNT_WIDTH              = $clog2(CALENDAR_DEPTH + 1);

  typedef logic [PIFO_ROOT_WIDTH-1:0]   pifo_desc_t;
  typedef logic [PIFO_RANK_WIDTH-1:0]   pifo_rank_t;
  typedef logic [BUFFER_ADDR_WIDTH-1:0] pifo_addr_t;

  // Per-cycle array operation broadcast to every cell.
  typedef enum logic [1:0] {
    OpHold,
    OpInsert,
    OpPop,
    OpPopInsert
  } cal_op_e;

  function automatic pifo_rank_t get_rank(input pifo_desc_t d);
    return d[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
  endfunction

  function automatic logic get_valid(input pifo_desc_t d);
    return d[ROOT_PIFO_INFO_VALID_POS];
  endfunction

  function automatic pifo_addr_t get_addr(input pifo_desc_t d);
    return d[BUFFER_ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pifo_calendar_cell.sv
// One calendar slot. Decides whether the incoming descriptor lands here and
// picks hold / shift-up / shift-down / load-new for its next value.
module pifo_calendar_cell
  import pifo_root_pkg::*;
#(
  parameter bit IS_HEAD = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  cal_op_e    op,
  input  pifo_desc_t new_desc,
  input  pifo_desc_t prev_desc,
  input  pifo_desc_t next_desc,
  input  logic       prev_ge,
  input  logic       next_ge,
  output logic       ge,
  output pifo_desc_t slot
);

  pifo_desc_t slot_q, slot_d;
  logic       shifted_prev_ge;

  // New entry sorts before this slot: slot empty or strictly larger rank,
  // so equal ranks keep arrival order.
  assign ge = !get_valid(slot_q) || (get_rank(slot_q) > get_rank(new_desc));

  // After a pop the array shifts up, so this cell's predecessor in the shifted
  // array is the entry currently held here; the head has no predecessor.
  assign shifted_prev_ge = IS_HEAD ? 1'b0 : ge;

  // Next-state selection for this slot.
  always_comb begin
    slot_d = slot_q;
    unique case (op)
      OpInsert: begin
        if (ge && !prev_ge)     slot_d = new_desc;
        else if (ge && prev_ge) slot_d = prev_desc;
      end
      OpPop: slot_d = next_desc;
      OpPopInsert: begin
        if (next_ge && !shifted_prev_ge)     slot_d = new_desc;
        else if (next_ge && shifted_prev_ge) slot_d = slot_q;
        else                                 slot_d = next_desc;
      end
      default: slot_d = slot_q;
    endcase
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot = slot_q;

endmodule

// File: rtl/pifo_root_calendar.sv
// Root PIFO calendar: rank-sorted descriptor store with bypass and dequeue.
// Optional build macro PIFO_CALENDAR_DROP_STATS_EN enables the drop counter.
module pifo_root_calendar
  import pifo_root_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_axis_valid,
  input  logic [PIFO_ROOT_WIDTH-1:0] s_axis_pifo_info,
  input  logic                       s_axis_bypass_en,
  input  logic                       m_axis_deq_ready,
  output logic                       m_axis_valid,
  output logic [PIFO_ROOT_WIDTH-1:0] m_axis_pifo_info,
  output logic [PIFO_ROOT_WIDTH-1:0] calendar_top,
  output logic [COUNT_WIDTH-1:0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                drop_count
);

  pifo_desc_t             slot [CALENDAR_DEPTH];
  logic                   ge   [CALENDAR_DEPTH];
  cal_op_e                op;
  logic                   push_acc;
  logic                   out_fire;
  pifo_desc_t             out_desc;
  logic                   drop_evt;
  logic [COUNT_WIDTH-1:0] occ_q, occ_d;
  logic                   m_valid_q;
  pifo_desc_t             m_info_q;

  assign push_acc = s_axis_valid && get_valid(s_axis_pifo_info);
  assign full     = (occ_q == COUNT_WIDTH'(CALENDAR_DEPTH));
  assign empty    = (occ_q == '0);

  for (genvar i = 0; i < CALENDAR_DEPTH; i++) begin : g_cell
    pifo_desc_t prev_desc, next_desc;
    logic       prev_ge, next_ge;

    if (i == 0) begin : g_head
      assign prev_desc = '0;
      assign prev_ge   = 1'b0;
    end else begin : g_mid
      assign prev_desc = slot[i-1];
      assign prev_ge   = ge[i-1];
    end

    // Beyond the tail behaves as an empty slot.
    if (i == CALENDAR_DEPTH - 1) begin : g_tail
      assign next_desc = '0;
      assign next_ge   = 1'b1;
    end else begin : g_body
      assign next_desc = slot[i+1];
      assign next_ge   = ge[i+1];
    end

    pifo_calendar_cell #(
      .IS_HEAD (i == 0)
    ) u_cell (
      .clk       (clk),
      .rstn      (rstn),
      .op        (op),
      .new_desc  (s_axis_pifo_info),
      .prev_desc (prev_desc),
      .next_desc (next_desc),
      .prev_ge   (prev_ge),
      .next_ge   (next_ge),
      .ge        (ge[i]),
      .slot      (slot[i])
    );
  end

  // Per-cycle decode of push / bypass / dequeue into an array op and output.
  always_comb begin
    op       = OpHold;
    out_fire = 1'b0;
    out_desc = slot[0];
    drop_evt = 1'b0;
    occ_d    = occ_q;
    if (push_acc && m_axis_deq_ready) begin
      out_fire = 1'b1;
      if (s_axis_bypass_en || empty) out_desc = s_axis_pifo_info;
      else                           op       = OpPopInsert;
    end else if (push_acc) begin
      if (!full) begin
        op    = OpInsert;
        occ_d = occ_q + COUNT_WIDTH'(1);
      end else begin
        // Full: a bypass still sorts to the head and evicts the tail;
        // either way one descriptor is lost.
        drop_evt = 1'b1;
        if (s_axis_bypass_en) op = OpInsert;
      end
    end else if (m_axis_deq_ready && !empty) begin
      op       = OpPop;
      out_fire = 1'b1;
      occ_d    = occ_q - COUNT_WIDTH'(1);
    end
  end

  // Occupancy and registered output port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ_q     <= '0;
      m_valid_q <= 1'b0;
      m_info_q  <= '0;
    end else begin
      occ_q     <= occ_d;
      m_valid_q <= out_fire;
      if (out_fire) m_info_q <= out_desc;
    end
  end

`ifdef PIFO_CALENDAR_DROP_STATS_EN
  logic [15:0] drop_q;

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rstn)                                drop_q <= '0;
    else if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_count = drop_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
  assign drop_count      = '0;
`endif

  assign m_axis_valid     = m_valid_q;
  assign m_axis_pifo_info = m_info_q;
  assign occupancy        = occ_q;

  // Head view for the bypass checker; valid bit masked when nothing is stored.
  always_comb begin
    calendar_top = slot[0];
    calendar_top[ROOT_PIFO_INFO_VALID_POS] = slot[0][ROOT_PIFO_INFO_VALID_POS] && !empty;
  end

endmodule
